// File: rtl/truth_table_sequencer_pkg.sv
// truth_table_sequencer_pkg: shared FSM states and constants for the truth-table sequencer.
package truth_table_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
    localparam int N_IN_DEF = 3;
    localparam int NVEC = 2 ** N_IN_DEF;
    // f = NOR(XOR(x,y),z) with x on the vector MSB is true only for 000 and 110
    localparam logic [NVEC-1:0] SOLVE_TT = 8'h41;
endpackage

// File: rtl/truth_table_sequencer_if.sv
// truth_table_sequencer_if: control, result and function-unit signals of the sequencer.
interface truth_table_sequencer_if
    import truth_table_sequencer_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
);
    logic                  start;
    logic                  abort;
    logic [2**N_IN-1:0]    expected;
    logic [N_IN-1:0]       dut_data;
    logic                  dut_f;
    logic                  busy;
    logic                  done;
    logic [2**N_IN-1:0]    tt;
    logic                  result_valid;
    logic                  match;
    logic [N_IN:0]         err_count;
    logic [N_IN-1:0]       first_err;
    modport master (
        output start, abort, expected, dut_f,
        input  dut_data, busy, done, tt, result_valid, match, err_count, first_err
    );
    modport slave (
        input  start, abort, expected, dut_f,
        output dut_data, busy, done, tt, result_valid, match, err_count, first_err
    );
endinterface

// File: rtl/truth_table_sequencer_settle.sv
// truth_table_sequencer_settle: SETTLE-cycle down-counter; expire is high on the last held cycle.
module truth_table_sequencer_settle #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);
    localparam int W = SETTLE > 1 ? $clog2(SETTLE) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= W'(SETTLE - 1);
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expire = cnt == '0;
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps all input vectors, samples the function unit and grades it against a golden table.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input logic clk,
    input logic rst,
    truth_table_sequencer_if.slave bus
);
    localparam int NV = 2 ** N_IN;
    state_t state, state_n;
    logic [N_IN-1:0] idx, ferr_q;
    logic [NV-1:0] exp_q, tt_q;
    logic [N_IN:0] err_q;
    logic rv_q, expire, load, last, miss, accept, stop;
    assign last   = &idx;
    assign accept = state == IDLE && bus.start;
    assign stop   = bus.abort && (state == DRIVE || state == SAMPLE);
    assign miss   = bus.dut_f != exp_q[idx];
    truth_table_sequencer_settle #(.SETTLE(SETTLE)) u_settle (
        .clk(clk), .rst(rst), .load(load), .expire(expire)
    );
    always_comb begin
        state_n = stop ? IDLE :
                  state == IDLE   ? (bus.start ? DRIVE : IDLE) :
                  state == DRIVE  ? (expire ? SAMPLE : DRIVE) :
                  state == SAMPLE ? (last ? DONE : DRIVE) : IDLE;
        load = state_n == DRIVE && state != DRIVE;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // abort keeps the partial table but returns the vector to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            {idx, exp_q, tt_q, err_q, ferr_q, rv_q} <= '0;
        end else if (stop) begin
            idx <= '0;
        end else if (accept) begin
            exp_q <= bus.expected;
            idx   <= '0;
            tt_q  <= '0;
            err_q <= '0;
            ferr_q <= '0;
            rv_q  <= 1'b0;
        end else if (state == SAMPLE) begin
            tt_q[idx] <= bus.dut_f;
            if (miss) begin
                err_q <= err_q + 1'b1;
                if (err_q == '0) ferr_q <= idx;
            end
            if (last) rv_q <= 1'b1;
            else idx <= idx + 1'b1;
        end
    end
    assign bus.dut_data     = idx;
    assign bus.busy         = state == DRIVE || state == SAMPLE;
    assign bus.done         = state == DONE;
    assign bus.tt           = tt_q;
    assign bus.result_valid = rv_q;
    assign bus.match        = rv_q && err_q == '0;
    assign bus.err_count    = err_q;
    assign bus.first_err    = ferr_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: directed checks of the sequencer driving a solve unit, SETTLE=1 and SETTLE=3.
module tb_truth_table_sequencer;
    logic clk = 1'b0;
    logic rst, rst3;
    int n_chk = 0, n_fail = 0, ndone1 = 0;
    int cyc, bad, d0;
    always #5 clk = ~clk;
    truth_table_sequencer_if #(.N_IN(3)) b1 ();
    truth_table_sequencer_if #(.N_IN(3)) b3 ();
    truth_table_sequencer #(.N_IN(3), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    truth_table_sequencer #(.N_IN(3), .SETTLE(3)) dut3 (.clk(clk), .rst(rst3), .bus(b3.slave));
    assign b1.dut_f = ~((b1.dut_data[2] ^ b1.dut_data[1]) | b1.dut_data[0]);
    assign b3.dut_f = ~((b3.dut_data[2] ^ b3.dut_data[1]) | b3.dut_data[0]);
    always @(negedge clk) if (b1.done) ndone1++;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic sweep1(input logic [7:0] e, input bit noise, output int n);
        b1.expected = e;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        n = 1;
        while (!b1.done && n < 200) begin
            if (noise && n % 5 == 2) begin
                b1.start = 1'b1;
                b1.expected = ~b1.expected;
            end
            tick();
            b1.start = 1'b0;
            n++;
        end
    endtask
    initial begin
        rst = 1'b1; rst3 = 1'b1;
        b1.start = 1'b0; b1.abort = 1'b0; b1.expected = 8'hff;
        b3.start = 1'b0; b3.abort = 1'b0; b3.expected = 8'hff;
        tick(); tick();
        check("reset1", {b1.busy, b1.done, b1.result_valid, b1.match, b1.tt, b1.err_count, b1.first_err, b1.dut_data}, 0);
        check("reset3", {b3.busy, b3.done, b3.result_valid, b3.match, b3.tt, b3.err_count, b3.first_err, b3.dut_data}, 0);
        rst = 1'b0; rst3 = 1'b0;
        tick();
        sweep1(8'h41, 1'b0, cyc);
        check("s1_latency", cyc, 17);
        check("s1_tt", b1.tt, 8'h41);
        check("s1_match", b1.match, 1);
        check("s1_err", b1.err_count, 0);
        check("s1_valid", b1.result_valid, 1);
        check("s1_busy_done", b1.busy, 0);
        tick();
        check("s1_done_pulse", b1.done, 0);
        check("s1_hold_valid", b1.result_valid, 1);
        check("s1_hold_data", b1.dut_data, 7);
        sweep1(8'h43, 1'b0, cyc);
        check("s2_tt", b1.tt, 8'h41);
        check("s2_match", b1.match, 0);
        check("s2_err", b1.err_count, 1);
        check("s2_first", b1.first_err, 1);
        tick();
        sweep1(8'hbe, 1'b0, cyc);
        check("s3_err", b1.err_count, 8);
        check("s3_first", b1.first_err, 0);
        check("s3_match", b1.match, 0);
        check("s3_valid", b1.result_valid, 1);
        tick();
        b1.expected = 8'h41;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        repeat (5) tick();
        check("s4_pre_data", b1.dut_data, 2);
        check("s4_valid_cleared", b1.result_valid, 0);
        b1.abort = 1'b1;
        d0 = ndone1;
        tick();
        b1.abort = 1'b0;
        check("s4_busy", b1.busy, 0);
        check("s4_data", b1.dut_data, 0);
        repeat (20) tick();
        check("s4_no_done", ndone1, d0);
        check("s4_valid", b1.result_valid, 0);
        check("s4_partial_tt", b1.tt, 8'h01);
        b1.abort = 1'b1;
        tick();
        b1.abort = 1'b0;
        sweep1(8'h41, 1'b0, cyc);
        check("s4_restart_lat", cyc, 17);
        check("s4_restart_match", b1.match, 1);
        tick();
        d0 = ndone1;
        sweep1(8'h41, 1'b1, cyc);
        check("s5_latency", cyc, 17);
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        check("s5_start_in_done", b1.busy, 0);
        repeat (3) tick();
        check("s5_one_done", ndone1, d0 + 1);
        check("s5_match", b1.match, 1);
        check("s5_tt", b1.tt, 8'h41);
        sweep1(8'h43, 1'b0, cyc);
        tick();
        b1.expected = 8'h41;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        check("s5_start_after_done", b1.busy, 1);
        cyc = 1;
        while (!b1.done && cyc < 200) begin tick(); cyc++; end
        check("s5_after_lat", cyc, 17);
        check("s5_after_match", b1.match, 1);
        b3.expected = 8'h41;
        b3.start = 1'b1;
        tick();
        b3.start = 1'b0;
        cyc = 1;
        bad = 0;
        while (!b3.done && cyc < 200) begin
            if (b3.dut_data != 3'((cyc - 1) / 4)) bad++;
            tick();
            cyc++;
        end
        check("s6_latency", cyc, 33);
        check("s6_stable", bad, 0);
        check("s6_match", b3.match, 1);
        check("s6_tt", b3.tt, 8'h41);
        tick();
        b3.expected = 8'h43;
        b3.start = 1'b1;
        tick();
        b3.start = 1'b0;
        repeat (9) tick();
        check("s6_mid_busy", b3.busy, 1);
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        check("s6_rst_mid", {b3.busy, b3.done, b3.result_valid, b3.match, b3.tt, b3.err_count, b3.first_err, b3.dut_data}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
